// File: rtl/nes_pad_pkg.sv
// Shared types and button bit positions for the NES pad reader and the
// controller-port emulation.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } pad_state_t;

  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value.
module pad_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Polls a 4021-based NES pad: latch pulse, 8 serial samples, parallel result.
// Optional macro NES_PAD_DPAD_FILTER_EN clears opposing d-pad pairs.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int POLL_CYCLES     = 833333,
  parameter int LATCH_CYCLES    = 600,
  parameter int HALF_BIT_CYCLES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid
);

  localparam int PW     = $clog2(POLL_CYCLES);
  localparam int PH_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int PHW    = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_BIT_CYCLES - 1);

  pad_state_t     state, next_state;
  logic [PW-1:0]  poll_cnt;
  logic [PHW-1:0] phase_cnt, phase_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg, filt;
  logic           data_s;
  logic           start, sample, finish;

  pad_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_s)
  );

  assign start = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    phase_next = phase_cnt;
    sample     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LATCH;
          phase_next = LATCH_LAST;
        end
      end
      LATCH: begin
        if (phase_cnt == '0) begin
          next_state = LOW;
          phase_next = HALF_LAST;
        end else begin
          phase_next = phase_cnt - PHW'(1);
        end
      end
      LOW: begin
        if (phase_cnt == '0) begin
          sample     = 1'b1;
          phase_next = HALF_LAST;
          // eighth sample ends the frame without a trailing clock pulse
          next_state = (bit_cnt == 3'd7) ? DONE : HIGH;
        end else begin
          phase_next = phase_cnt - PHW'(1);
        end
      end
      HIGH: begin
        if (phase_cnt == '0) begin
          next_state = LOW;
          phase_next = HALF_LAST;
        end else begin
          phase_next = phase_cnt - PHW'(1);
        end
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef NES_PAD_DPAD_FILTER_EN
  always_comb begin
    filt = shreg;
    if (shreg[BTN_UP] && shreg[BTN_DOWN]) begin
      filt[BTN_UP]   = 1'b0;
      filt[BTN_DOWN] = 1'b0;
    end
    if (shreg[BTN_LEFT] && shreg[BTN_RIGHT]) begin
      filt[BTN_LEFT]  = 1'b0;
      filt[BTN_RIGHT] = 1'b0;
    end
  end
`else
  assign filt = shreg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt  <= '0;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      buttons   <= '0;
      valid     <= 1'b0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
    end else begin
      poll_cnt  <= start ? '0 : poll_cnt + PW'(1);
      phase_cnt <= phase_next;
      // pin outputs follow the state they belong to, from its first cycle
      pad_latch <= (next_state == LATCH);
      pad_clk   <= (next_state == HIGH);
      valid     <= finish;
      if (sample) begin
        shreg   <= {shreg[6:0], ~data_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (finish) begin
        bit_cnt <= '0;
        buttons <= filt;
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader with a behavioural 4021 pad model
// and a scoreboard of expected button words.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid;
  logic [7:0] buttons;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .POLL_CYCLES     (64),
    .LATCH_CYCLES    (4),
    .HALF_BIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid)
  );

  // 4021 model: parallel load while latch high, shift on pad_clk rise
  logic [7:0] word = 8'h00;
  logic [7:0] q4021 = 8'h00;
  logic       tie = 1'b0;
  logic       pclk_d = 1'b0;

  always @(posedge clk) begin
    if (pad_latch === 1'b1)
      q4021 <= word;
    else if (pad_clk === 1'b1 && pclk_d === 1'b0)
      q4021 <= {q4021[6:0], 1'b0};
    pclk_d <= pad_clk;
  end

  assign pad_data = tie ? 1'b1 : ~q4021[7];

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  function automatic logic [7:0] filt(input logic [7:0] x);
    logic [7:0] r;
    r = x;
`ifdef NES_PAD_DPAD_FILTER_EN
    if (x[3] && x[2]) r[3:2] = 2'b00;
    if (x[1] && x[0]) r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  // scoreboard / protocol monitor
  logic [7:0] sb[$];
  logic [7:0] last_exp = 8'h00;
  logic [7:0] latched_word = 8'h00;
  logic [7:0] exp_b;
  logic       latched_tie = 1'b0;
  logic       prev_latch = 1'b0;
  logic       prev_clk = 1'b0;
  bit         skip_period = 1'b1;
  int         lat_cnt = 0;
  int         clk_rises = 0;
  int         lat_age = -1;
  int         since_valid = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      last_exp    = 8'h00;
      lat_cnt     = 0;
      clk_rises   = 0;
      lat_age     = -1;
      since_valid = 0;
      skip_period = 1'b1;
      prev_latch  = 1'b0;
      prev_clk    = 1'b0;
    end else begin
      if (lat_age >= 0) lat_age++;
      since_valid++;
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_pop actual=valid_without_transaction required=no_valid");
        end else begin
          exp_b = sb.pop_front();
          check("sb_buttons", buttons, exp_b);
          last_exp = exp_b;
        end
        check("pad_clk_pulses", clk_rises, 7);
        check("latch_to_valid", lat_age, 35);
        if (!skip_period) check("valid_period", since_valid, 64);
        skip_period = 1'b0;
        since_valid = 0;
        lat_age     = -1;
        clk_rises   = 0;
      end else begin
        check("buttons_hold", buttons, last_exp);
      end
      if (pad_latch && !prev_latch) begin
        lat_age   = 0;
        lat_cnt   = 0;
        clk_rises = 0;
      end
      if (pad_latch) begin
        lat_cnt++;
        latched_word = word;
        latched_tie  = tie;
      end
      if (!pad_latch && prev_latch) begin
        check("latch_width", lat_cnt, 4);
        sb.push_back(latched_tie ? 8'h00 : filt(latched_word));
      end
      if (pad_clk && !prev_clk) clk_rises++;
      prev_latch = pad_latch;
      prev_clk   = pad_clk;
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_valid");
  endtask

  task automatic wait_latch_fall(output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (pad_latch) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_latch_fall");
  endtask

  typedef struct {
    logic [7:0] load;
    logic [7:0] late;
    logic       tie;
    logic [7:0] exp_raw;
    logic [7:0] exp_filt;
  } vec_t;

  initial begin
    vec_t v[8];
    bit   ok;
    int   n;

    v[0] = '{8'h90, 8'h90, 1'b0, 8'h90, 8'h90};  // A+Start
    v[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'h00};  // all released
    v[2] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00};  // pad_data tied high
    v[3] = '{8'h01, 8'h80, 1'b0, 8'h01, 8'h01};  // change mid-shift
    v[4] = '{8'h80, 8'h80, 1'b0, 8'h80, 8'h80};  // change shows next frame
    v[5] = '{8'h4E, 8'h4E, 1'b0, 8'h4E, 8'h42};  // Up+Down+Left+B
    v[6] = '{8'hC3, 8'hC3, 1'b0, 8'hC3, 8'hC0};  // Left+Right
    v[7] = '{8'h0F, 8'h0F, 1'b0, 8'h0F, 8'h00};  // whole d-pad

    repeat (3) @(posedge clk);
    #1;
    check("reset_latch", pad_latch, 1'b0);
    check("reset_clk", pad_clk, 1'b0);
    check("reset_buttons", buttons, 8'h00);
    check("reset_valid", valid, 1'b0);
    reset = 1'b0;

    wait_valid(ok);

    for (int i = 0; i < 8; i++) begin
      word = v[i].load;
      tie  = v[i].tie;
      wait_latch_fall(ok);
      word = v[i].late;
      wait_valid(ok);
`ifdef NES_PAD_DPAD_FILTER_EN
      check($sformatf("vec%0d_buttons", i), buttons, v[i].exp_filt);
`else
      check($sformatf("vec%0d_buttons", i), buttons, v[i].exp_raw);
`endif
    end

    // reset during the HIGH phase following the third sample
    word = 8'h90;
    tie  = 1'b0;
    n = 0;
    while (!(clk_rises == 3 && pad_clk) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) timeout_fail("wait_bit3_high");
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_latch", pad_latch, 1'b0);
    check("midrst_clk", pad_clk, 1'b0);
    check("midrst_buttons", buttons, 8'h00);
    check("midrst_valid", valid, 1'b0);
    reset = 1'b0;
    n = 0;
    while (!valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_to_first_valid", n, 99);
    check("post_reset_buttons", buttons, 8'h90);

    word = 8'h00;
    wait_valid(ok);
    check("final_buttons", buttons, 8'h00);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
